// File: rtl/ring_decode_check_if.sv
// Ring-word receive bus: sampled ring word in, decoded index and lock/error status out.
interface ring_decode_check_if #(
   parameter int ERRW = 8
);
   logic [15:0]     r_in;
   logic            r_valid;
   logic [3:0]      q_out;
   logic            onehot_ok;
   logic            locked;
   logic            err;
   logic            wrap;
   logic [ERRW-1:0] err_cnt;

   modport master (
      output r_in, r_valid,
      input  q_out, onehot_ok, locked, err, wrap, err_cnt
   );

   modport slave (
      input  r_in, r_valid,
      output q_out, onehot_ok, locked, err, wrap, err_cnt
   );
endinterface

// File: rtl/ring_decode_check.sv
// One-hot ring word decoder with HUNT/LOCKED sequence checker.
// Optional saturating error counter enabled by defining RING_ERRCNT_EN.
module ring_decode_check #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2,
   parameter int ERRW       = 8
) (
   input logic               clk,
   input logic               nRST,
   ring_decode_check_if.slave bus
);

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

   function automatic logic [4:0] popcount16(input logic [15:0] w);
      logic [4:0] c;
      c = 5'd0;
      for (int i = 0; i < 16; i++) begin
         c = c + {4'd0, w[i]};
      end
      return c;
   endfunction

   function automatic logic [3:0] encode16(input logic [15:0] w);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         idx = w[i] ? 4'(i) : idx;
      end
      return idx;
   endfunction

   state_t     state_r, state_nxt_s;
   logic [3:0] q_r, q_nxt_s;
   logic       ok_r, ok_nxt_s;
   logic       err_r, err_nxt_s;
   logic       wrap_r, wrap_nxt_s;
   logic       have_prev_r, have_prev_nxt_s;
   logic [3:0] good_cnt_r, good_cnt_nxt_s;
   logic [3:0] bad_cnt_r, bad_cnt_nxt_s;

   logic       legal_s;
   logic [3:0] idx_s;
   logic       step_ok_s;
   logic       good_s;
   logic       bad_s;

   // q_r always holds the last legal index, so it doubles as the previous position.
   assign legal_s   = (popcount16(bus.r_in) == 5'd1);
   assign idx_s     = encode16(bus.r_in);
   assign step_ok_s = (idx_s == (q_r + 4'd1));
   assign good_s    = bus.r_valid & legal_s & have_prev_r & step_ok_s;
   assign bad_s     = bus.r_valid & (~legal_s | (have_prev_r & ~step_ok_s));

   // Next-state, counter and pulse logic.
   always_comb begin
      state_nxt_s     = state_r;
      q_nxt_s         = q_r;
      ok_nxt_s        = ok_r;
      have_prev_nxt_s = have_prev_r;
      good_cnt_nxt_s  = good_cnt_r;
      bad_cnt_nxt_s   = bad_cnt_r;
      err_nxt_s       = 1'b0;
      wrap_nxt_s      = 1'b0;

      if (bus.r_valid) begin
         if (legal_s) begin
            q_nxt_s         = idx_s;
            ok_nxt_s        = 1'b1;
            have_prev_nxt_s = 1'b1;
         end else begin
            ok_nxt_s        = 1'b0;
            have_prev_nxt_s = 1'b0;
         end
      end else begin
         ok_nxt_s = ok_r;
      end

      case (state_r)
         HUNT: begin
            if (good_s) begin
               if ((good_cnt_r + 4'd1) == LOCK_C) begin
                  state_nxt_s    = LOCKED;
                  good_cnt_nxt_s = 4'd0;
                  bad_cnt_nxt_s  = 4'd0;
               end else begin
                  good_cnt_nxt_s = good_cnt_r + 4'd1;
               end
            end else if (bad_s) begin
               good_cnt_nxt_s = 4'd0;
            end else begin
               good_cnt_nxt_s = good_cnt_r;
            end
         end
         LOCKED: begin
            if (good_s) begin
               bad_cnt_nxt_s = 4'd0;
               wrap_nxt_s    = (q_r == 4'd15) && (idx_s == 4'd0);
            end else if (bad_s) begin
               err_nxt_s = 1'b1;
               if ((bad_cnt_r + 4'd1) == UNLOCK_C) begin
                  state_nxt_s    = HUNT;
                  good_cnt_nxt_s = 4'd0;
                  bad_cnt_nxt_s  = 4'd0;
               end else begin
                  bad_cnt_nxt_s = bad_cnt_r + 4'd1;
               end
            end else begin
               bad_cnt_nxt_s = bad_cnt_r;
            end
         end
         default: begin
            state_nxt_s    = HUNT;
            good_cnt_nxt_s = 4'd0;
            bad_cnt_nxt_s  = 4'd0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_r     <= HUNT;
         q_r         <= 4'd0;
         ok_r        <= 1'b0;
         err_r       <= 1'b0;
         wrap_r      <= 1'b0;
         have_prev_r <= 1'b0;
         good_cnt_r  <= 4'd0;
         bad_cnt_r   <= 4'd0;
      end else begin
         state_r     <= state_nxt_s;
         q_r         <= q_nxt_s;
         ok_r        <= ok_nxt_s;
         err_r       <= err_nxt_s;
         wrap_r      <= wrap_nxt_s;
         have_prev_r <= have_prev_nxt_s;
         good_cnt_r  <= good_cnt_nxt_s;
         bad_cnt_r   <= bad_cnt_nxt_s;
      end
   end

   assign bus.q_out     = q_r;
   assign bus.onehot_ok = ok_r;
   assign bus.locked    = (state_r == LOCKED);
   assign bus.err       = err_r;
   assign bus.wrap      = wrap_r;

`ifdef RING_ERRCNT_EN
   logic [ERRW-1:0] err_cnt_r;

   // Saturating error counter; advances on the same edge that raises err.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         err_cnt_r <= '0;
      end else if (err_nxt_s && (err_cnt_r != {ERRW{1'b1}})) begin
         err_cnt_r <= err_cnt_r + ERRW'(1);
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign bus.err_cnt = err_cnt_r;
`else
   assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_decode_check.sv
// Randomized self-checking bench for ring_decode_check against a behavioural model.
module tb_ring_decode_check;

`ifdef RING_ERRCNT_EN
   localparam int ERRW = 2;
`else
   localparam int ERRW = 8;
`endif
   localparam int LOCK_CNT   = 4;
   localparam int UNLOCK_CNT = 2;

   logic clk;
   logic nRST;

   ring_decode_check_if #(.ERRW(ERRW)) bus ();

   ring_decode_check #(
      .LOCK_CNT  (LOCK_CNT),
      .UNLOCK_CNT(UNLOCK_CNT),
      .ERRW      (ERRW)
   ) dut (
      .clk (clk),
      .nRST(nRST),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   // behavioural model state
   int m_q, m_good, m_bad, m_cnt;
   bit m_ok, m_locked, m_err, m_wrap, m_have;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_q = 0; m_good = 0; m_bad = 0; m_cnt = 0;
      m_ok = 0; m_locked = 0; m_err = 0; m_wrap = 0; m_have = 0;
   endtask

   task automatic model_step(input logic [15:0] w, input logic v);
      int  idx;
      bit  legal, good, bad;
      m_err  = 0;
      m_wrap = 0;
      if (!v) return;
      legal = ($countones(w) == 1);
      idx   = legal ? $clog2(w) : 0;
      good  = legal && m_have && (idx == (m_q + 1) % 16);
      bad   = !legal || (m_have && (idx != (m_q + 1) % 16));
      if (!m_locked) begin
         if (good) begin
            m_good++;
            if (m_good == LOCK_CNT) begin
               m_locked = 1; m_good = 0; m_bad = 0;
            end
         end else if (bad) m_good = 0;
      end else begin
         if (good) begin
            m_bad  = 0;
            m_wrap = (m_q == 15) && (idx == 0);
         end else if (bad) begin
            m_err = 1;
            m_bad++;
            if (m_bad == UNLOCK_CNT) begin
               m_locked = 0; m_good = 0; m_bad = 0;
            end
         end
      end
`ifdef RING_ERRCNT_EN
      if (m_err && m_cnt < (2 ** ERRW) - 1) m_cnt++;
`endif
      if (legal) begin
         m_q = idx; m_ok = 1; m_have = 1;
      end else begin
         m_ok = 0; m_have = 0;
      end
   endtask

   task automatic compare_all();
      chk("q_out",     int'(bus.q_out),     m_q);
      chk("onehot_ok", int'(bus.onehot_ok), int'(m_ok));
      chk("locked",    int'(bus.locked),    int'(m_locked));
      chk("err",       int'(bus.err),       int'(m_err));
      chk("wrap",      int'(bus.wrap),      int'(m_wrap));
      chk("err_cnt",   int'(bus.err_cnt),   m_cnt);
   endtask

   // One sampled cycle: drive, advance model, check after the edge.
   task automatic cyc(input logic [15:0] w, input logic v);
      bus.r_in    = w;
      bus.r_valid = v;
      model_step(w, v);
      @(posedge clk);
      #2;
      compare_all();
   endtask

   function automatic logic [15:0] nxt_word();
      logic [15:0] one;
      one = 16'd1;
      return one << ((m_q + 1) % 16);
   endfunction

   function automatic int sat_cnt(input int n);
`ifdef RING_ERRCNT_EN
      return (n > 3) ? 3 : n;
`else
      return 0;
`endif
   endfunction

   initial begin
      logic [15:0] one;
      int          r;
      one = 16'd1;
      model_reset();
      bus.r_in    = 16'h0000;
      bus.r_valid = 1'b0;
      nRST        = 1'b0;
      #23;
      chk("rst_q_out",     int'(bus.q_out),     0);
      chk("rst_onehot_ok", int'(bus.onehot_ok), 0);
      chk("rst_locked",    int'(bus.locked),    0);
      chk("rst_err_cnt",   int'(bus.err_cnt),   0);
      nRST = 1'b1;
      @(posedge clk);
      #2;

      // acquire lock: first word only seeds prev, four good steps lock
      cyc(16'h0001, 1'b1);
      cyc(16'h0002, 1'b1);
      cyc(16'h0004, 1'b1);
      cyc(16'h0008, 1'b1);
      chk("pre_lock", int'(bus.locked), 0);
      cyc(16'h0010, 1'b1);
      chk("lock_locked", int'(bus.locked), 1);
      chk("lock_q", int'(bus.q_out), 4);
      chk("lock_err", int'(bus.err), 0);

      // walk to 13, then 14, 15, 0 for the wrap pulse
      for (int i = 5; i <= 13; i++) cyc(one << i, 1'b1);
      cyc(16'h4000, 1'b1);
      chk("q14", int'(bus.q_out), 14);
      cyc(16'h8000, 1'b1);
      chk("q15", int'(bus.q_out), 15);
      chk("no_wrap15", int'(bus.wrap), 0);
      cyc(16'h0001, 1'b1);
      chk("wrap_pulse", int'(bus.wrap), 1);
      chk("wrap_q0", int'(bus.q_out), 0);
      chk("wrap_locked", int'(bus.locked), 1);
      cyc(16'h0002, 1'b1);
      chk("wrap_once", int'(bus.wrap), 0);

      // illegal words while locked at 5
      for (int i = 2; i <= 5; i++) cyc(one << i, 1'b1);
      cyc(16'h0003, 1'b1);
      chk("multi_ok", int'(bus.onehot_ok), 0);
      chk("multi_q", int'(bus.q_out), 5);
      chk("multi_err", int'(bus.err), 1);
      chk("multi_locked", int'(bus.locked), 1);
      chk("cnt1", int'(bus.err_cnt), sat_cnt(1));
      cyc(16'h0000, 1'b1);
      chk("zero_err", int'(bus.err), 1);
      chk("unlock", int'(bus.locked), 0);
      chk("cnt2", int'(bus.err_cnt), sat_cnt(2));

      // relock at 5, then a jump that resyncs
      for (int i = 0; i <= 5; i++) cyc(one << i, 1'b1);
      chk("relock", int'(bus.locked), 1);
      cyc(16'h0100, 1'b1);
      chk("jump_err", int'(bus.err), 1);
      chk("jump_locked", int'(bus.locked), 1);
      chk("cnt3", int'(bus.err_cnt), sat_cnt(3));
      cyc(16'h0200, 1'b1);
      chk("resync_err", int'(bus.err), 0);
      chk("resync_q", int'(bus.q_out), 9);
      chk("resync_locked", int'(bus.locked), 1);

      // two more err pulses, counter saturates when narrow
      cyc(16'h0000, 1'b1);
      chk("cnt4", int'(bus.err_cnt), sat_cnt(4));
      cyc(16'h0400, 1'b1);
      cyc(16'h0000, 1'b1);
      chk("cnt5", int'(bus.err_cnt), sat_cnt(5));

      // idle with garbage on r_in
      for (int i = 0; i < 10; i++) begin
         cyc(16'($urandom), 1'b0);
         chk("idle_err", int'(bus.err), 0);
      end

      // randomized mostly-walking stream
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(99);
         if (r < 75)      cyc(nxt_word(), 1'b1);
         else if (r < 83) cyc(16'($urandom), 1'b0);
         else if (r < 89) cyc(one << $urandom_range(15), 1'b1);
         else if (r < 94) cyc(16'h0000, 1'b1);
         else             cyc(16'($urandom), 1'b1);
      end

      // asynchronous reset in the middle of a cycle
      #1;
      nRST = 1'b0;
      #1;
      chk("arst_q_out",     int'(bus.q_out),     0);
      chk("arst_onehot_ok", int'(bus.onehot_ok), 0);
      chk("arst_locked",    int'(bus.locked),    0);
      chk("arst_err",       int'(bus.err),       0);
      chk("arst_wrap",      int'(bus.wrap),      0);
      chk("arst_err_cnt",   int'(bus.err_cnt),   0);
      model_reset();
      @(negedge clk);
      nRST = 1'b1;
      @(posedge clk);
      #2;
      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(99);
         if (r < 85) cyc(nxt_word(), 1'b1);
         else        cyc(16'($urandom), 1'b1);
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
